// File: rtl/watchdog_pkg.sv
// Shared types and constants for the bus-side watchdog timer.
package watchdog_pkg;

    // Watchdog operating states.
    typedef enum logic {
        RUN  = 1'b0,
        FIRE = 1'b1
    } wdog_state_e;

    // Data byte that constitutes a valid kick unless overridden.
    localparam logic [7:0] WDOG_KEY_DEFAULT = 8'h39;

    // Width of the saturating firing counter.
    localparam int unsigned FIRE_CNT_W = 4;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [FIRE_CNT_W-1:0] sat_inc(input logic [FIRE_CNT_W-1:0] v);
        return (&v) ? v : v + FIRE_CNT_W'(1);
    endfunction

endpackage

// File: rtl/watchdog_pulse_gen.sv
// Start-triggered fixed-width pulse generator driving the system reset request.
// A start while idle raises the pulse on that edge; it stays high for exactly
// PULSE_CYCLES cycles. busy drops during the final pulse cycle so the owner can
// leave its FIRE state on the same edge that ends the pulse.
module watchdog_pulse_gen #(
    parameter int unsigned PULSE_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic pulse
);

    localparam int unsigned      PC_W    = $clog2(PULSE_CYCLES + 1);
    localparam logic [PC_W-1:0]  PC_LAST = PC_W'(PULSE_CYCLES - 1);

    logic [PC_W-1:0] pc_q, pc_d;
    logic            pulse_q, pulse_d;

    // Next-state: count pulse cycles while active, launch on start when idle.
    always_comb begin
        pulse_d = pulse_q;
        pc_d    = pc_q;
        if (pulse_q) begin
            if (pc_q == PC_LAST) begin
                pulse_d = 1'b0;
                pc_d    = '0;
            end else begin
                pc_d = pc_q + PC_W'(1);
            end
        end else if (start) begin
            pulse_d = 1'b1;
            pc_d    = '0;
        end
    end

    // State register; reset abandons any pulse in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pulse_q <= 1'b0;
            pc_q    <= '0;
        end else begin
            pulse_q <= pulse_d;
            pc_q    <= pc_d;
        end
    end

    assign pulse = pulse_q;
    assign busy  = pulse_q && (pc_q != PC_LAST);

endmodule

// File: rtl/watchdog_timer.sv
// Bus-side watchdog: counts frame ticks, re-armed by writing KEY through the
// decoder select, fires a fixed-width sys_reset pulse on timeout.
// Optional macro WATCHDOG_STRICT_KEY_EN: a select write with a wrong key while
// running fires the watchdog immediately.
module watchdog_timer
    import watchdog_pkg::*;
#(
    parameter int unsigned TIMEOUT_TICKS = 8,
    parameter int unsigned PULSE_CYCLES  = 64,
    parameter logic [7:0]  KEY           = WDOG_KEY_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sel_n,
    input  logic                  wr,
    input  logic [7:0]            d,
    input  logic                  tick,
    output logic                  sys_reset,
    output logic [FIRE_CNT_W-1:0] fire_count
);

    localparam int unsigned       CNT_W    = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_TICKS - 1);

    wdog_state_e            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [FIRE_CNT_W-1:0]  fire_count_q, fire_count_d;
    logic                   sel_wr, kick, bad_key, fire;
    logic                   pulse_busy, pulse;

    assign sel_wr = !sel_n && wr;
    assign kick   = sel_wr && (d == KEY);

`ifdef WATCHDOG_STRICT_KEY_EN
    assign bad_key = sel_wr && (d != KEY);
`else
    assign bad_key = 1'b0;
`endif

    // Next-state: kicks beat ticks; an expiring tick or bad key launches FIRE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fire    = 1'b0;
        unique case (state_q)
            RUN: begin
                if (kick) begin
                    cnt_d = '0;
                end else if (bad_key) begin
                    fire = 1'b1;
                end else if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        fire = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                if (fire) begin
                    state_d = FIRE;
                    cnt_d   = '0;
                end
            end
            FIRE: begin
                // Inputs ignored; leave on the edge that ends the pulse.
                cnt_d = '0;
                if (!pulse_busy) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Saturating count of RUN->FIRE transitions.
    always_comb begin
        fire_count_d = fire ? sat_inc(fire_count_q) : fire_count_q;
    end

    // State, tick counter and firing counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            cnt_q        <= '0;
            fire_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fire_count_q <= fire_count_d;
        end
    end

    watchdog_pulse_gen #(
        .PULSE_CYCLES (PULSE_CYCLES)
    ) u_pulse_gen (
        .clk   (clk),
        .reset (reset),
        .start (fire),
        .busy  (pulse_busy),
        .pulse (pulse)
    );

    assign sys_reset  = pulse;
    assign fire_count = fire_count_q;

endmodule

// File: tb/tb_watchdog_timer.sv
// Self-checking bench for watchdog_timer with a cycle-level reference model
// feeding an expected-output queue.
module tb_watchdog_timer;
    import watchdog_pkg::*;

    localparam int unsigned T = 8;
    localparam int unsigned P = 64;
    localparam logic [7:0]  K = WDOG_KEY_DEFAULT;
`ifdef WATCHDOG_STRICT_KEY_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       sel_n;
    logic       wr;
    logic [7:0] d;
    logic       tick;
    logic       sys_reset;
    logic [3:0] fire_count;

    typedef struct packed {
        logic       sys;
        logic [3:0] fc;
    } exp_t;

    exp_t  sb_q[$];
    int    tests_run = 0;
    int    tests_failed = 0;
    string scen = "init";

    // Reference model state
    bit m_fire;
    int m_cnt;
    int m_rem;
    int m_fc;

    always #5 clk = ~clk;

    watchdog_timer #(
        .TIMEOUT_TICKS (T),
        .PULSE_CYCLES  (P),
        .KEY           (K)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sel_n      (sel_n),
        .wr         (wr),
        .d          (d),
        .tick       (tick),
        .sys_reset  (sys_reset),
        .fire_count (fire_count)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        tests_run++;
        if (obs != exp) begin
            tests_failed++;
            $display("FAIL %s %s: got %0d expected %0d", scen, tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic s_n, input logic w, input logic [7:0] dv,
                              input logic tk);
        bit k, bad, fire_now;
        k        = !s_n && w && (dv == K);
        bad      = !s_n && w && (dv != K);
        fire_now = 1'b0;
        if (m_fire) begin
            m_rem--;
            if (m_rem == 0) begin
                m_fire = 1'b0;
                m_cnt  = 0;
            end
        end else begin
            if (k) m_cnt = 0;
            else if (STRICT && bad) fire_now = 1'b1;
            else if (tk) begin
                m_cnt++;
                if (m_cnt == T) fire_now = 1'b1;
            end
            if (fire_now) begin
                m_fire = 1'b1;
                m_rem  = P;
                m_cnt  = 0;
                if (m_fc < 15) m_fc++;
            end
        end
    endtask

    // One clock: drive, predict, sample 1 time unit after the edge, compare.
    task automatic cycle(input logic s_n, input logic w, input logic [7:0] dv, input logic tk);
        exp_t e, got;
        sel_n = s_n;
        wr    = w;
        d     = dv;
        tick  = tk;
        model_step(s_n, w, dv, tk);
        e.sys = m_fire;
        e.fc  = 4'(m_fc);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        sel_n = 1'b1;
        wr    = 1'b0;
        tick  = 1'b0;
        got = sb_q.pop_front();
        check_eq("sys_reset", int'(sys_reset), int'(got.sys));
        check_eq("fire_count", int'(fire_count), int'(got.fc));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_tick(input int gap);
        cycle(1'b1, 1'b0, 8'h00, 1'b1);
        if (gap > 1) idle(gap - 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check_eq("reset sys_reset", int'(sys_reset), 0);
        check_eq("reset fire_count", int'(fire_count), 0);
        m_fire = 1'b0;
        m_cnt  = 0;
        m_rem  = 0;
        m_fc   = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int n;
        bit seen;
        sel_n = 1'b1;
        wr    = 1'b0;
        d     = 8'h00;
        tick  = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        // No kicks, ticks every 100 cycles
        scen = "timeout";
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 1'b0, 8'h00, 1'b1);
            if (i < 8) begin
                check_eq("pre-fire", int'(sys_reset), 0);
                idle(99);
            end
        end
        check_eq("rise", int'(sys_reset), 1);
        n = 1;
        for (int g = 0; g < 200; g++) begin
            idle(1);
            if (sys_reset) n++;
            else break;
        end
        check_eq("pulse width", n, 64);
        check_eq("count", int'(fire_count), 1);

        // Regular kicks keep it quiet
        scen = "kicked";
        do_reset();
        seen = 1'b0;
        for (int t = 1; t <= 50; t++) begin
            if (t % 7 == 0) cycle(1'b0, 1'b1, K, 1'b0);
            do_tick(5);
            seen |= sys_reset;
        end
        check_eq("never fired", int'(seen), 0);
        check_eq("count", int'(fire_count), 0);

        // Kick and tick together at cnt=7
        scen = "kick+tick";
        do_reset();
        for (int i = 0; i < 7; i++) do_tick(3);
        cycle(1'b0, 1'b1, K, 1'b1);
        check_eq("no fire", int'(sys_reset), 0);
        for (int i = 0; i < 7; i++) begin
            do_tick(1);
            check_eq("quiet", int'(sys_reset), 0);
        end
        do_tick(1);
        check_eq("8th fires", int'(sys_reset), 1);
        idle(P + 2);
        check_eq("count", int'(fire_count), 1);

        // Wrong key at cnt=3
        scen = "badkey";
        do_reset();
        for (int i = 0; i < 3; i++) do_tick(2);
        cycle(1'b0, 1'b1, 8'h38, 1'b0);
        if (STRICT) begin
            check_eq("immediate fire", int'(sys_reset), 1);
            check_eq("count", int'(fire_count), 1);
        end else begin
            check_eq("ignored", int'(sys_reset), 0);
            for (int i = 0; i < 4; i++) begin
                do_tick(2);
                check_eq("quiet", int'(sys_reset), 0);
            end
            do_tick(1);
            check_eq("5th fires", int'(sys_reset), 1);
        end
        idle(P + 2);

        // Reset in the middle of a pulse
        scen = "midreset";
        do_reset();
        for (int i = 0; i < 8; i++) do_tick(2);
        idle(9);
        check_eq("in pulse", int'(sys_reset), 1);
        do_reset();
        for (int i = 0; i < 7; i++) begin
            do_tick(2);
            check_eq("quiet", int'(sys_reset), 0);
        end
        do_tick(1);
        check_eq("refire", int'(sys_reset), 1);
        idle(P + 2);

        // Saturation over 17 expirations
        scen = "saturate";
        do_reset();
        for (int e = 1; e <= 17; e++) begin
            for (int i = 0; i < 8; i++) do_tick(2);
            idle(P + 1);
            if (e == 14) check_eq("after 14", int'(fire_count), 14);
            if (e == 15) check_eq("after 15", int'(fire_count), 15);
        end
        check_eq("after 17", int'(fire_count), 15);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
